// File: rtl/x_wave_seq_pkg.sv
`default_nettype none
// ============================================================================
// x_wave_seq_pkg : shared types and constants for the waveform sequencer
// Revision 1.0
// ============================================================================
package x_wave_seq_pkg;

  localparam int ADDR_W           = 11;
  localparam int DATA_W           = 2;
  localparam int ENTRIES_PER_BYTE = 4;
  localparam int CNT_W            = $clog2(ENTRIES_PER_BYTE);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    HOLD = 3'd4
  } state_t;

  // Entry idx of a loader byte; entry 0 lives in bits [1:0].
  function automatic data_t byte_entry(input logic [7:0] b, input cnt_t idx);
    logic [7:0] shifted;
    shifted = b >> {idx, 1'b0};
    return shifted[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_wave_seq_if.sv
`default_nettype none
// ============================================================================
// x_wave_seq_if : load stream, playback control, sample stream and memory port
// Revision 1.0
// ============================================================================
interface x_wave_seq_if;
  import x_wave_seq_pkg::*;

  logic       i_load_valid;
  logic [7:0] i_load_data;
  logic       o_load_ready;
  logic       i_load_clr;
  logic       i_start;
  logic       i_stop;
  addr_t      i_len;
  logic       i_loop;
  logic       o_sample_valid;
  data_t      o_sample;
  logic       i_sample_ready;
  logic       o_busy;
  addr_t      o_mem_addr;
  logic       o_mem_we;
  data_t      o_mem_wdata;
  data_t      i_mem_rdata;

  modport master (
    input  i_load_valid, i_load_data, i_load_clr, i_start, i_stop, i_len, i_loop,
           i_sample_ready, i_mem_rdata,
    output o_load_ready, o_sample_valid, o_sample, o_busy, o_mem_addr, o_mem_we,
           o_mem_wdata
  );

  modport slave (
    output i_load_valid, i_load_data, i_load_clr, i_start, i_stop, i_len, i_loop,
           i_sample_ready, i_mem_rdata,
    input  o_load_ready, o_sample_valid, o_sample, o_busy, o_mem_addr, o_mem_we,
           o_mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/x_wave_seq.sv
`default_nettype none
// ============================================================================
// x_wave_seq : loads packed bytes into the 2048x2 sample memory and streams
//              entries 0..len back out, optionally looping. Revision 1.0
// ============================================================================
module x_wave_seq
  import x_wave_seq_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  x_wave_seq_if.master  bus
);

  state_t     state_q, state_d;
  addr_t      wr_ptr_q, wr_ptr_d;
  addr_t      rd_ptr_q, rd_ptr_d;
  addr_t      len_q, len_d;
  logic       loop_q, loop_d;
  logic [7:0] byte_q, byte_d;
  cnt_t       cnt_q, cnt_d;
  data_t      sample_q, sample_d;
  logic       sample_valid_q, sample_valid_d;

  addr_t      mem_addr;
  logic       mem_we;
  data_t      mem_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      len_q          <= '0;
      loop_q         <= 1'b0;
      byte_q         <= '0;
      cnt_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      len_q          <= len_d;
      loop_q         <= loop_d;
      byte_q         <= byte_d;
      cnt_q          <= cnt_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    len_d          = len_q;
    loop_d         = loop_q;
    byte_d         = byte_q;
    cnt_d          = cnt_q;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;

    unique case (state_q)
      IDLE: begin
        // Load beats start beats clear; lower-priority requests are dropped.
        if (bus.i_load_valid) begin
          byte_d  = bus.i_load_data;
          cnt_d   = '0;
          state_d = LOAD;
        end else if (bus.i_start) begin
          rd_ptr_d = '0;
          len_d    = bus.i_len;
          loop_d   = bus.i_loop;
          state_d  = RD;
        end else if (bus.i_load_clr) begin
          wr_ptr_d = '0;
        end
      end

      LOAD: begin
        wr_ptr_d = wr_ptr_q + addr_t'(1);
        cnt_d    = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(ENTRIES_PER_BYTE - 1)) begin
          state_d = IDLE;
        end
      end

      RD: begin
        if (bus.i_stop) begin
          sample_valid_d = 1'b0;
          state_d        = IDLE;
        end else begin
          state_d = CAP;
        end
      end

      CAP: begin
        if (bus.i_stop) begin
          sample_valid_d = 1'b0;
          state_d        = IDLE;
        end else begin
          sample_d       = bus.i_mem_rdata;
          sample_valid_d = 1'b1;
          state_d        = HOLD;
        end
      end

      HOLD: begin
        if (bus.i_stop) begin
          sample_valid_d = 1'b0;
          state_d        = IDLE;
        end else if (bus.i_sample_ready) begin
          sample_valid_d = 1'b0;
          if (rd_ptr_q != len_q) begin
            rd_ptr_d = rd_ptr_q + addr_t'(1);
            state_d  = RD;
          end else if (loop_q) begin
            rd_ptr_d = '0;
            state_d  = RD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port is a pure decode of registered state, never of inputs.
  always_comb begin
    mem_addr  = wr_ptr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      LOAD: begin
        mem_we    = 1'b1;
        mem_wdata = byte_entry(byte_q, cnt_q);
      end
      RD, CAP, HOLD: begin
        mem_addr = rd_ptr_q;
      end
      default: begin
        mem_addr = wr_ptr_q;
      end
    endcase
  end

  assign bus.o_mem_addr     = mem_addr;
  assign bus.o_mem_we       = mem_we;
  assign bus.o_mem_wdata    = mem_wdata;
  assign bus.o_load_ready   = (state_q == IDLE);
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_sample       = sample_q;
  assign bus.o_sample_valid = sample_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_x_wave_seq.sv
`default_nettype none
// ============================================================================
// tb_x_wave_seq : sequencer bench with a behavioural sample memory and model
// Revision 1.0
// ============================================================================
module tb_x_wave_seq;
  import x_wave_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x_wave_seq_if bus();

  x_wave_seq dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Stand-in for x_mem_2p_2048x2: read data valid the cycle after, held on writes.
  data_t mem [0:2047];
  always @(posedge clk) begin
    if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    else              bus.i_mem_rdata     <= mem[bus.o_mem_addr];
  end

  addr_t wr_addr_log[$];
  data_t wr_data_log[$];
  always @(negedge clk) begin
    if (bus.o_mem_we) begin
      wr_addr_log.push_back(bus.o_mem_addr);
      wr_data_log.push_back(bus.o_mem_wdata);
    end
  end

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  data_t ref_mem [0:2047];
  int    ref_wr = 0;
  data_t got[$];
  int    got_cyc[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_load(input logic [7:0] b);
    for (int k = 0; k < 4; k++) begin
      ref_mem[ref_wr] = data_t'((b >> (2 * k)) & 8'h3);
      ref_wr = (ref_wr + 1) % 2048;
    end
  endtask

  function automatic data_t exp_sample(input int i, input int len);
    return ref_mem[i % (len + 1)];
  endfunction

  task automatic load_byte(input logic [7:0] b, output int low_cycles);
    bus.i_load_valid = 1'b1;
    bus.i_load_data  = b;
    tick();
    bus.i_load_valid = 1'b0;
    model_load(b);
    low_cycles = 0;
    while (!bus.o_load_ready && low_cycles < 20) begin
      low_cycles++;
      tick();
    end
  endtask

  task automatic do_start(input int len, input bit loop, output int c0);
    bus.i_len   = addr_t'(len);
    bus.i_loop  = loop;
    bus.i_start = 1'b1;
    c0 = cyc;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic collect(input int n, input int budget, input bit rnd_ready);
    int waited;
    waited = 0;
    got.delete();
    got_cyc.delete();
    while (got.size() < n && waited < budget) begin
      bus.i_sample_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.o_sample_valid && bus.i_sample_ready) begin
        got.push_back(bus.o_sample);
        got_cyc.push_back(cyc);
      end
      tick();
      waited++;
    end
  endtask

  task automatic stop_in_hold(input string name, input data_t last);
    int w;
    bus.i_sample_ready = 1'b0;
    w = 0;
    while (!bus.o_sample_valid && w < 20) begin
      tick();
      w++;
    end
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    checks++;
    if (bus.o_sample_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_sample !== last) begin
      errors++;
      $display("FAIL %s_stop: valid=%0b busy=%0b sample=%0d, required valid=0 busy=0 sample=%0d",
               name, bus.o_sample_valid, bus.o_busy, bus.o_sample, last);
    end
  endtask

  task automatic test_reset();
    bus.i_load_valid = 0; bus.i_load_data = 0; bus.i_load_clr = 0;
    bus.i_start = 0; bus.i_stop = 0; bus.i_len = 0; bus.i_loop = 0;
    bus.i_sample_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_load_ready !== 1'b1 || bus.o_sample_valid !== 1'b0 ||
        bus.o_sample !== 2'd0 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b ready=%0b valid=%0b sample=%0d we=%0b addr=%0d, required 0 1 0 0 0 0",
               bus.o_busy, bus.o_load_ready, bus.o_sample_valid, bus.o_sample, bus.o_mem_we, bus.o_mem_addr);
    end
    bus.i_load_valid = 1'b1;
    bus.i_load_data  = 8'hFF;
    tick();
    bus.i_load_valid = 1'b0;
    tick();
    checks++;
    if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 11'd1) begin
      errors++;
      $display("FAIL reset_preload: we=%0b addr=%0d, required we=1 addr=1", bus.o_mem_we, bus.o_mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_load_ready !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: busy=%0b ready=%0b we=%0b addr=%0d, required 0 1 0 0",
               bus.o_busy, bus.o_load_ready, bus.o_mem_we, bus.o_mem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    ref_wr = 0;
    ref_mem[0] = 2'd3;
  endtask

  task automatic test_load();
    int    lc1, lc2;
    addr_t exp_a;
    data_t exp_d [0:7];
    exp_d = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    wr_addr_log.delete();
    wr_data_log.delete();
    load_byte(8'hE4, lc1);
    load_byte(8'h1B, lc2);
    checks++;
    if (lc1 != 4 || lc2 != 4) begin
      errors++;
      $display("FAIL load_ready_low: got %0d and %0d cycles, required 4 and 4", lc1, lc2);
    end
    checks++;
    if (wr_addr_log.size() != 8) begin
      errors++;
      $display("FAIL load_write_count: got %0d writes, required 8", wr_addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_a = addr_t'(i);
        checks++;
        if (wr_addr_log[i] !== exp_a || wr_data_log[i] !== exp_d[i]) begin
          errors++;
          $display("FAIL load_write%0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                   i, wr_addr_log[i], wr_data_log[i], exp_a, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_play();
    int c0, bad;
    do_start(7, 1'b0, c0);
    collect(8, 60, 1'b0);
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL play_count: got %0d samples, required 8", got.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 8; i++) if (got[i] !== exp_sample(i, 7)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL play_data: %0d wrong samples, first got %0d required %0d", bad, got[0], exp_sample(0, 7));
      end
      checks++;
      if (got_cyc[0] != c0 + 3) begin
        errors++;
        $display("FAIL play_latency: first valid %0d cycles after start, required 3", got_cyc[0] - c0);
      end
      bad = 0;
      for (int i = 1; i < 8; i++) if (got_cyc[i] - got_cyc[i-1] != 3) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL play_spacing: %0d gaps differ, required all gaps 3", bad);
      end
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL play_busy_end: busy=%0b, required 0", bus.o_busy);
    end
  endtask

  task automatic test_backpressure_loop();
    int c0, w, bad;
    bus.i_sample_ready = 1'b0;
    do_start(1, 1'b1, c0);
    w = 0;
    while (!bus.o_sample_valid && w < 10) begin
      tick();
      w++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_sample_valid !== 1'b1 || bus.o_sample !== exp_sample(0, 1)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, required sample %0d valid 1 throughout", bad, exp_sample(0, 1));
    end
    collect(6, 40, 1'b0);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_sample(i, 1)) bad++;
    checks++;
    if (got.size() != 6 || bad != 0) begin
      errors++;
      $display("FAIL bp_loop_stream: got %0d samples with %0d wrong, required 6 alternating 0/1", got.size(), bad);
    end
    stop_in_hold("bp", exp_sample(6, 1));
  endtask

  task automatic test_wrap();
    int lc, badlc, bad, bad_spec, c0;
    data_t spec_v;
    bus.i_load_clr = 1'b1;
    tick();
    bus.i_load_clr = 1'b0;
    ref_wr = 0;
    badlc = 0;
    for (int i = 0; i < 512; i++) begin
      load_byte(8'hE4, lc);
      if (lc != 4) badlc++;
    end
    load_byte(8'h00, lc);
    if (lc != 4) badlc++;
    checks++;
    if (badlc != 0) begin
      errors++;
      $display("FAIL wrap_ready_low: %0d bytes with ready low != 4 cycles, required 0", badlc);
    end
    do_start(2047, 1'b0, c0);
    collect(2048, 2048 * 3 + 20, 1'b0);
    bad = 0;
    bad_spec = 0;
    for (int i = 0; i < got.size(); i++) begin
      spec_v = (i < 4) ? 2'd0 : data_t'(i % 4);
      if (got[i] !== exp_sample(i, 2047)) bad++;
      if (got[i] !== spec_v) bad_spec++;
    end
    checks++;
    if (got.size() != 2048 || bad != 0) begin
      errors++;
      $display("FAIL wrap_model: got %0d samples with %0d wrong, required 2048 matching model", got.size(), bad);
    end
    checks++;
    if (got.size() != 2048 || bad_spec != 0) begin
      errors++;
      $display("FAIL wrap_pattern: got %0d samples with %0d off pattern, required 0,0,0,0 then 0,1,2,3 repeating",
               got.size(), bad_spec);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_busy_end: busy=%0b, required 0", bus.o_busy);
    end
  endtask

  task automatic test_collision();
    logic [7:0] b;
    int seen;
    b = 8'($urandom);
    bus.i_load_valid = 1'b1;
    bus.i_load_data  = b;
    bus.i_start      = 1'b1;
    bus.i_len        = 11'd3;
    bus.i_loop       = 1'b1;
    bus.i_sample_ready = 1'b1;
    tick();
    bus.i_load_valid = 1'b0;
    bus.i_start      = 1'b0;
    model_load(b);
    checks++;
    if (bus.o_mem_we !== 1'b1 || bus.o_load_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL coll_load_taken: we=%0b ready=%0b busy=%0b, required 1 0 1",
               bus.o_mem_we, bus.o_load_ready, bus.o_busy);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_sample_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_no_play: %0d valid cycles busy=%0b, required 0 valid cycles busy=0", seen, bus.o_busy);
    end
  endtask

  task automatic test_len0();
    int c0, seen;
    do_start(0, 1'b0, c0);
    collect(1, 20, 1'b1);
    checks++;
    if (got.size() != 1 || got[0] !== exp_sample(0, 0) || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_single: got %0d samples busy=%0b, required 1 sample %0d busy=0",
               got.size(), bus.o_busy, exp_sample(0, 0));
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_sample_valid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL len0_extra: %0d valid cycles after end, required 0", seen);
    end
  endtask

  task automatic test_random(input int iter);
    int lc, len, n, bad, c0;
    bit loop;
    bus.i_load_clr = 1'b1;
    tick();
    bus.i_load_clr = 1'b0;
    ref_wr = 0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      load_byte(8'($urandom), lc);
    end
    len  = $urandom_range(0, 31);
    loop = 1'($urandom_range(0, 1));
    n    = loop ? 3 * (len + 1) + 2 : len + 1;
    do_start(len, loop, c0);
    collect(n, n * 40 + 20, 1'b1);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== exp_sample(i, len)) bad++;
    checks++;
    if (got.size() != n || bad != 0) begin
      errors++;
      $display("FAIL rand%0d_stream: len=%0d loop=%0b got %0d samples with %0d wrong, required %0d",
               iter, len, loop, got.size(), bad, n);
    end
    if (loop) begin
      stop_in_hold("rand", exp_sample(n, len));
    end else begin
      checks++;
      if (bus.o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_end: busy=%0b, required 0", iter, bus.o_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_play();
    test_backpressure_loop();
    test_collision();
    test_len0();
    for (int it = 0; it < 4; it++) test_random(it);
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/x_wave_seq.md
Name: x_wave_seq

Overview:
- Controller and sequencer that owns the single address/WE port of the team's 2048x2 sample memory, x_mem_2p_2048x2.
- Upstream: accepts bytes from the loader (UART/SPI side), unpacks each byte into four 2-bit entries and writes them to consecutive addresses.
- Downstream: on command, reads entries 0..len back in order and presents them on a valid/ready stream to the DAC modulator.
- Optional continuous looping.

Parameters:
- ADDR_W, 11, memory address width (2048 entries).
- DATA_W, 2, memory entry width.

Ports:
- i_clk, in, 1, system clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_load_valid, in, 1, load byte valid.
- i_load_data, in, 8, load byte; bits [1:0] are stored first.
- o_load_ready, out, 1, byte accepted when valid & ready.
- i_load_clr, in, 1, pulse; zeroes write pointer (honoured in IDLE only).
- i_start, in, 1, pulse; begin playback from address 0.
- i_stop, in, 1, pulse; abort playback.
- i_len, in, ADDR_W, last address to play (inclusive); captured at start.
- i_loop, in, 1, wrap to 0 after last address; captured at start.
- o_sample_valid, out, 1, sample stream valid.
- o_sample, out, DATA_W, sample data.
- i_sample_ready, in, 1, downstream ready.
- o_busy, out, 1, high in any state other than IDLE.
- o_mem_addr, out, ADDR_W, memory address.
- o_mem_we, out, 1, memory write enable.
- o_mem_wdata, out, DATA_W, memory write data.
- i_mem_rdata, in, DATA_W, memory read data.
  - Valid the cycle after an edge with we=0.
  - Holds its value while we=1.

Behaviour:
- States: IDLE, LOAD, RD, CAP, HOLD.
- Reset (async, any state): state=IDLE, wr_ptr=0, rd_ptr=0, o_sample=0, o_sample_valid=0, o_busy=0.
- Memory port outputs are combinational decodes of registered state and pointers only; there is no input-to-output path.
  - o_load_ready = (state==IDLE), so it is 1 out of reset.
- IDLE: o_mem_addr=wr_ptr, o_mem_we=0, o_mem_wdata=0. Priority in IDLE:
  - 1. Load byte accepted: latch the byte, cnt=0, go to LOAD.
  - 2. i_start: rd_ptr=0, capture i_len and i_loop, go to RD.
  - 3. i_load_clr: wr_ptr=0.
  - Any lower-priority inputs in the same cycle are dropped.
- LOAD: four cycles with cnt=0..3.
  - o_mem_we=1, o_mem_addr=wr_ptr, o_mem_wdata=byte[2cnt+1:2cnt].
  - wr_ptr increments every cycle; it is modulo 2048, so 2047 wraps to 0.
  - After cnt==3, go to IDLE.
  - i_start, i_stop and i_load_clr are ignored while in LOAD.
  - Peak load rate: one byte per 5 cycles.
- RD: o_mem_addr=rd_ptr, o_mem_we=0; go to CAP.
- CAP: at the clock edge, o_sample<=i_mem_rdata and o_sample_valid<=1; go to HOLD.
- HOLD: o_sample and o_sample_valid are held stable until i_sample_ready.
  - On handshake, o_sample_valid<=0.
  - If rd_ptr != len: rd_ptr++, go to RD.
  - Else if loop: rd_ptr=0, go to RD.
  - Else go to IDLE.
- Latency: i_start seen in cycle 0 gives o_sample_valid=1 in cycle 3.
  - Steady state with ready held high: one sample per 3 cycles.
- i_stop in RD, CAP or HOLD: next state IDLE, o_sample_valid<=0, o_sample keeps its last value.
  - i_stop wins over a same-cycle handshake.
- len=0: a single sample is played, or entry 0 repeats if looping.
- Playback never writes memory; wr_ptr is untouched by playback.

Decomposition:
- Package x_wave_seq_pkg holds:
  - ADDR_W, DATA_W;
  - ENTRIES_PER_BYTE=4;
  - the typedef enum state_t {IDLE, LOAD, RD, CAP, HOLD};
  - the typedef addr_t.
- No sub-module. The parent instantiates x_mem_2p_2048x2 alongside this block: o_mem_* drive its i_addr/i_we/i_wdata, and its o_rdata drives i_mem_rdata.

Test Plan:
- Reset:
  - Assert i_rst mid-LOAD with byte 0xFF at cnt=1.
  - Required: o_busy=0, o_load_ready=1, o_mem_we=0 immediately.
  - Required: after release, wr_ptr=0, so the next byte writes address 0.
- Load:
  - Load 0xE4 then 0x1B from wr_ptr 0.
  - Required writes: addr0..3 = 0,1,2,3 and addr4..7 = 3,2,1,0.
  - Required: o_load_ready low for exactly 4 cycles per byte.
- Play:
  - i_start with len=7, loop=0, ready held 1.
  - Required: samples 0,1,2,3,3,2,1,0, first valid 3 cycles after start, 3-cycle spacing.
  - Required: o_busy falls after the 8th handshake.
- Backpressure and loop:
  - len=1, loop=1, ready low for 10 cycles in HOLD.
  - Required: o_sample stable at 0 throughout; after release, the stream is 1,0,1,0...
  - Then pulse i_stop in HOLD: valid drops the next cycle and the state goes to IDLE.
- Wrap:
  - After i_load_clr, load 512 bytes 0xE4 (2048 entries), then one more byte 0x00.
  - Required: addr0..3 overwritten with 0.
  - Required: play with len=2047 yields 0,0,0,0 followed by 0,1,2,3 repeated.
- Collision:
  - In IDLE, assert i_load_valid and i_start in the same cycle.
  - Required: load accepted, start dropped, and no sample appears.
